// File: rtl/cpu_ctrl_seq_if.sv
// Sequencer bus: program-counter feedback, fetched instruction and datapath
// flags in; phase-aligned strobes, PC load and control state out.
interface cpu_ctrl_seq_if;
  logic [1:0] upc;
  logic [7:0] pc;
  logic [7:0] instr;
  logic       acc_zero;
  logic       irq;
  logic       pc_load;
  logic [7:0] pc_addr;
  logic [7:0] ir;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       acc_load;
  logic [1:0] alu_op;
  logic       halted;
  logic       irq_ack;
  logic       ie;

  // Environment side: program counter, program memory, datapath
  modport master (
    output upc, pc, instr, acc_zero, irq,
    input  pc_load, pc_addr, ir, mem_addr, mem_rd, mem_wr, acc_load,
           alu_op, halted, irq_ack, ie
  );

  // Sequencer side
  modport slave (
    input  upc, pc, instr, acc_zero, irq,
    output pc_load, pc_addr, ir, mem_addr, mem_rd, mem_wr, acc_load,
           alu_op, halted, irq_ack, ie
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer: follows the 4-phase micro-cycle from the PC,
// latches the instruction and issues registered, phase-aligned strobes.
// Owns every non-sequential PC change (jump, halt hold, irq entry, return).
module cpu_ctrl_seq #(
  parameter logic [7:0] VECTOR = 8'hF0
) (
  input logic          clk,
  input logic          rst,
  cpu_ctrl_seq_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_STA = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_SYS = 3'd7
  } opcode_e;

  localparam logic [4:0] SYS_HLT = 5'd0;
  localparam logic [4:0] SYS_RET = 5'd1;
  localparam logic [4:0] SYS_EI  = 5'd2;
  localparam logic [4:0] SYS_DI  = 5'd3;

  logic [7:0] ir_q, epc_q, pc_addr_q;
  logic       ie_q, pc_load_q, mem_rd_q, mem_wr_q, acc_load_q;
  logic       halted_q, irq_ack_q;
  logic [1:0] alu_op_q;

  opcode_e    op, fop;
  logic [4:0] opr;
  logic [7:0] tgt, seq_pc, cont;
  logic       ld_n, take;
  logic [7:0] addr_n;

  assign op  = opcode_e'(ir_q[7:5]);
  assign opr = ir_q[4:0];
  assign fop = opcode_e'(bus.instr[7:5]);

  // Phase-3 flow decision from the latched instruction; cont is where the
  // program would carry on, saved as the return address on irq entry.
  always_comb begin
    tgt    = {bus.pc[7:5], opr};
    seq_pc = bus.pc + 8'd1;
    ld_n   = 1'b0;
    addr_n = 8'h00;
    cont   = seq_pc;
    take   = bus.irq & ie_q;
    case (op)
      OP_JMP: begin
        ld_n   = 1'b1;
        addr_n = tgt;
        cont   = tgt;
      end
      OP_JZ: begin
        if (bus.acc_zero) begin
          ld_n   = 1'b1;
          addr_n = tgt;
          cont   = tgt;
        end
      end
      OP_SYS: begin
        if (opr == SYS_HLT) begin
          ld_n   = 1'b1;
          addr_n = bus.pc;
        end else if (opr == SYS_RET) begin
          ld_n   = 1'b1;
          addr_n = epc_q;
          cont   = epc_q;
        end
      end
      default: ;
    endcase
  end

  // Strobes are set on the edge before their phase and cleared otherwise,
  // so each is high for exactly one cycle of the micro-cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q       <= 8'h00;
      epc_q      <= 8'h00;
      ie_q       <= 1'b0;
      halted_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      acc_load_q <= 1'b0;
      alu_op_q   <= 2'd0;
      pc_load_q  <= 1'b0;
      pc_addr_q  <= 8'h00;
      irq_ack_q  <= 1'b0;
    end else begin
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      acc_load_q <= 1'b0;
      alu_op_q   <= 2'd0;
      pc_load_q  <= 1'b0;
      pc_addr_q  <= 8'h00;
      irq_ack_q  <= 1'b0;
      case (bus.upc)
        2'd0: begin
          ir_q     <= bus.instr;
          halted_q <= (bus.instr == {OP_SYS, SYS_HLT});
          mem_rd_q <= (fop == OP_LDA) || (fop == OP_ADD) || (fop == OP_SUB);
        end
        2'd1: begin
          case (op)
            OP_LDA: begin acc_load_q <= 1'b1; alu_op_q <= 2'd0; end
            OP_ADD: begin acc_load_q <= 1'b1; alu_op_q <= 2'd1; end
            OP_SUB: begin acc_load_q <= 1'b1; alu_op_q <= 2'd2; end
            OP_STA: mem_wr_q <= 1'b1;
            default: ;
          endcase
        end
        2'd2: begin
          if (take) begin
            pc_load_q <= 1'b1;
            pc_addr_q <= VECTOR;
            irq_ack_q <= 1'b1;
            epc_q     <= cont;
          end else begin
            pc_load_q <= ld_n;
            pc_addr_q <= addr_n;
          end
        end
        2'd3: begin
          // irq entry wins over any enable change the instruction asked for
          if (irq_ack_q) begin
            ie_q <= 1'b0;
          end else if (op == OP_SYS) begin
            if (opr == SYS_RET || opr == SYS_EI) ie_q <= 1'b1;
            else if (opr == SYS_DI)              ie_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ir       = ir_q;
  assign bus.mem_addr = ir_q[4:0];
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.acc_load = acc_load_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_addr  = pc_addr_q;
  assign bus.halted   = halted_q;
  assign bus.irq_ack  = irq_ack_q;
  assign bus.ie       = ie_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: models the program counter, program/data memory
// and accumulator around the sequencer, with a per-instruction scoreboard
// of expected strobes plus directed checks of program flow.
module tb_cpu_ctrl_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_seq_if bus ();
  cpu_ctrl_seq #(.VECTOR(8'hF0)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] upc;
  logic [7:0] pc;
  logic [7:0] acc = 8'd0;
  logic [7:0] rdata = 8'd0;
  logic [7:0] pmem [256];
  logic [7:0] dmem [32] = '{5: 8'd3, 6: 8'd4, default: 8'd0};

  assign bus.upc      = upc;
  assign bus.pc       = pc;
  assign bus.instr    = pmem[pc];
  assign bus.acc_zero = (acc == 8'd0);
  assign bus.irq      = irq;

  // Program counter, data memory and accumulator
  always @(posedge clk) begin
    if (rst) begin
      upc <= 2'd0;
      pc  <= 8'h00;
    end else begin
      upc <= upc + 2'd1;
      if (upc == 2'd3) pc <= bus.pc_load ? bus.pc_addr : pc + 8'd1;
    end
    if (bus.mem_rd) rdata <= dmem[bus.mem_addr];
    if (bus.mem_wr) dmem[bus.mem_addr] <= acc;
    if (bus.acc_load) begin
      case (bus.alu_op)
        2'd0:    acc <= rdata;
        2'd1:    acc <= acc + rdata;
        2'd2:    acc <= acc - rdata;
        default: acc <= acc;
      endcase
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       pc_load;
    logic [7:0] pc_addr;
    logic       irq_ack;
  } strb_t;

  strb_t q[$];
  strb_t e, o;
  logic [7:0] m_instr, m_pc, m_ir, m_epc, t_cont;
  logic       m_ie, m_take;

  // Scoreboard: each fetch queues the next phase's expected strobes; each
  // later phase pops/compares and queues the following phase.
  always @(negedge clk) begin
    o = {bus.mem_rd, bus.mem_wr, bus.acc_load, bus.alu_op,
         bus.pc_load, bus.pc_addr, bus.irq_ack};
    if (rst) begin
      q.delete();
      m_ie = 1'b0; m_epc = 8'h00; m_ir = 8'h00; m_take = 1'b0;
    end else begin
      if (upc == 2'd1) m_ir = m_instr;
      chk("ir", bus.ir, m_ir);
      chk("mem_addr", bus.mem_addr, m_ir[4:0]);
      chk("halted", bus.halted, m_ir == 8'hE0);
      chk("ie", bus.ie, m_ie);
      if (upc == 2'd0) begin
        chk("phase0 strobes", o, 0);
        m_instr = bus.instr;
        m_pc    = pc;
        e = '0;
        e.mem_rd = (m_instr[7:5] == 3'd1) || (m_instr[7:5] == 3'd3) ||
                   (m_instr[7:5] == 3'd4);
        q.push_back(e);
      end else begin
        if (q.size() == 0) chk("scoreboard empty", 0, 1);
        else begin
          e = q.pop_front();
          chk($sformatf("phase%0d strobes pc=%0h", upc, m_pc), o, e);
        end
        if (upc == 2'd1) begin
          e = '0;
          case (m_instr[7:5])
            3'd1: e.acc_load = 1'b1;
            3'd2: e.mem_wr = 1'b1;
            3'd3: begin e.acc_load = 1'b1; e.alu_op = 2'd1; end
            3'd4: begin e.acc_load = 1'b1; e.alu_op = 2'd2; end
            default: ;
          endcase
          q.push_back(e);
        end else if (upc == 2'd2) begin
          e = '0;
          t_cont = m_pc + 8'd1;
          if (m_instr[7:5] == 3'd5 || (m_instr[7:5] == 3'd6 && acc == 8'd0)) begin
            e.pc_load = 1'b1; e.pc_addr = {m_pc[7:5], m_instr[4:0]};
            t_cont = e.pc_addr;
          end else if (m_instr == 8'hE0) begin
            e.pc_load = 1'b1; e.pc_addr = m_pc;
          end else if (m_instr == 8'hE1) begin
            e.pc_load = 1'b1; e.pc_addr = m_epc;
            t_cont = m_epc;
          end
          if (irq && m_ie) begin
            e.pc_load = 1'b1; e.pc_addr = 8'hF0; e.irq_ack = 1'b1;
            m_epc = t_cont;
            m_take = 1'b1;
          end
          q.push_back(e);
        end else begin
          if (m_take) m_ie = 1'b0;
          else if (m_instr == 8'hE1 || m_instr == 8'hE2) m_ie = 1'b1;
          else if (m_instr == 8'hE3) m_ie = 1'b0;
          m_take = 1'b0;
        end
      end
    end
  end

  task automatic wait_fetch(input logic [7:0] a, input int bound, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (upc == 2'd0 && pc == a) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    pmem[8'h02] = 8'h25;  // LDA 5
    pmem[8'h03] = 8'h66;  // ADD 6
    pmem[8'h04] = 8'h47;  // STA 7
    pmem[8'h05] = 8'hDF;  // JZ 1F (not taken)
    pmem[8'h06] = 8'hAC;  // JMP 0C
    pmem[8'h0C] = 8'hE2;  // EI
    pmem[8'h10] = 8'hE0;  // HLT
    pmem[8'h11] = 8'hE3;  // DI
    pmem[8'h43] = 8'hBA;  // JMP 1A -> 5A
    pmem[8'h5A] = 8'h85;  // SUB 5
    pmem[8'h5B] = 8'h28;  // LDA 8 (zero)
    pmem[8'h5C] = 8'hDE;  // JZ 1E (taken) -> 5E
    pmem[8'h5E] = 8'h66;  // ADD 6, aborted by reset
    pmem[8'hF0] = 8'hE1;  // RET

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", {bus.mem_rd, bus.mem_wr, bus.acc_load, bus.alu_op,
                          bus.pc_load, bus.pc_addr, bus.irq_ack}, 0);
    chk("reset ir", bus.ir, 8'h00);
    chk("reset ie", bus.ie, 1'b0);
    chk("reset halted", bus.halted, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    chk("start pc", pc, 8'h00);
    repeat (4) @(negedge clk);
    chk("nop pc+1 after 4 cycles", pc, 8'h01);
    chk("nop upc", upc, 2'd0);

    wait_fetch(8'h05, 20, "reach 05");
    chk("mem[7] after STA", dmem[7], 8'd7);
    chk("acc after ADD", acc, 8'd7);
    wait_fetch(8'h06, 4, "JZ not taken -> 06");
    wait_fetch(8'h0C, 4, "JMP -> 0C");
    wait_fetch(8'h10, 20, "reach HLT");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("HLT pc holds", pc, 8'h10);
      chk("HLT halted", bus.halted, 1'b1);
    end

    @(posedge clk); #1 irq = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.irq_ack) begin
        ok = 1'b1;
        chk("irq_ack phase", upc, 2'd3);
        chk("irq vector", bus.pc_addr, 8'hF0);
        break;
      end
    end
    chk("irq_ack seen", ok, 1'b1);
    @(posedge clk); #1 irq = 1'b0;
    wait_fetch(8'hF0, 4, "entry -> F0");
    chk("ie cleared on entry", bus.ie, 1'b0);
    wait_fetch(8'h11, 4, "RET -> 11");
    chk("ie set by RET", bus.ie, 1'b1);

    wait_fetch(8'h43, 300, "reach 43");
    wait_fetch(8'h5A, 4, "JMP 1A -> 5A");
    @(posedge clk); #1 irq = 1'b1;
    wait_fetch(8'h5E, 16, "JZ taken -> 5E");
    chk("acc zero before ADD", acc, 8'd0);

    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid-ADD reset acc_load", bus.acc_load, 1'b0);
    chk("mid-ADD reset strobes", {bus.mem_rd, bus.mem_wr, bus.acc_load, bus.alu_op,
                                  bus.pc_load, bus.pc_addr, bus.irq_ack}, 0);
    chk("mid-ADD reset ir", bus.ir, 8'h00);
    chk("mid-ADD reset ie", bus.ie, 1'b0);
    chk("mid-ADD reset halted", bus.halted, 1'b0);
    repeat (6) @(negedge clk);
    chk("ADD aborted acc", acc, 8'd0);
    irq = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
